// File: rtl/reqrsp_buffer.sv
// reqrsp_buffer: per-channel FIFO (or combinational bypass) on a reqrsp link plus an in-flight request limiter.
// Link vectors are packed as req = {q, q_valid, p_ready} and rsp = {p, p_valid, q_ready}.

module reqrsp_buffer_fifo #(
    parameter int unsigned Width      = 8,
    parameter int unsigned Depth      = 2,
    parameter int unsigned UsageWidth = (Depth > 0) ? $clog2(Depth + 1) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_valid_i,
    input  logic [Width-1:0]      push_data_i,
    output logic                  push_ready_o,
    output logic                  pop_valid_o,
    output logic [Width-1:0]      pop_data_o,
    input  logic                  pop_ready_i,
    output logic [UsageWidth-1:0] usage_o
);

    if (Depth == 0) begin : gen_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign push_ready_o   = pop_ready_i;
        assign pop_valid_o    = push_valid_i;
        assign pop_data_o     = push_data_i;
        assign usage_o        = '0;
    end else begin : gen_fifo
        localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

        logic [Width-1:0]      mem_q [Depth];
        logic [PtrWidth-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
        logic [UsageWidth-1:0] usage_q, usage_d;
        logic                  push, pop;

        // Full/empty come from the usage count so any depth works, and both flags are registered.
        assign push_ready_o = (usage_q != UsageWidth'(Depth));
        assign pop_valid_o  = (usage_q != '0);
        assign pop_data_o   = mem_q[rptr_q];
        assign usage_o      = usage_q;
        assign push         = push_valid_i & push_ready_o;
        assign pop          = pop_valid_o & pop_ready_i;

        always_comb begin
            wptr_d  = wptr_q;
            rptr_d  = rptr_q;
            usage_d = usage_q;
            if (push) begin
                wptr_d = (wptr_q == PtrWidth'(Depth - 1)) ? '0 : wptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rptr_d = (rptr_q == PtrWidth'(Depth - 1)) ? '0 : rptr_q + PtrWidth'(1);
            end
            if (push && !pop) begin
                usage_d = usage_q + UsageWidth'(1);
            end else if (!push && pop) begin
                usage_d = usage_q - UsageWidth'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                usage_q <= '0;
            end else begin
                wptr_q  <= wptr_d;
                rptr_q  <= rptr_d;
                usage_q <= usage_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wptr_q] <= push_data_i;
            end
        end
    end

endmodule

module reqrsp_buffer #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned UserWidth      = 1,
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned RspDepth       = 2,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned QWidth        = AddrWidth + 1 + DataWidth + DataWidth / 8 + UserWidth,
    localparam int unsigned PWidth        = DataWidth + 1 + UserWidth,
    localparam int unsigned ReqUsageWidth = (ReqDepth > 0) ? $clog2(ReqDepth + 1) : 1,
    localparam int unsigned RspUsageWidth = (RspDepth > 0) ? $clog2(RspDepth + 1) : 1,
    localparam int unsigned OutWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [QWidth+1:0]        slv_req_i,
    output logic [PWidth+1:0]        slv_rsp_o,
    output logic [QWidth+1:0]        mst_req_o,
    input  logic [PWidth+1:0]        mst_rsp_i,
    output logic [ReqUsageWidth-1:0] req_usage_o,
    output logic [RspUsageWidth-1:0] rsp_usage_o,
    output logic [OutWidth-1:0]      outstanding_o
);

    logic [QWidth-1:0]   slv_q, mst_q;
    logic [PWidth-1:0]   mst_p, slv_p;
    logic                slv_q_valid, slv_q_ready, slv_p_valid, slv_p_ready;
    logic                mst_q_valid, mst_q_ready, mst_p_valid, mst_p_ready;
    logic                req_head_valid, credit_ok, issue, retire;
    logic [OutWidth-1:0] outstanding_q, outstanding_d;

    assign slv_q       = slv_req_i[QWidth+1:2];
    assign slv_q_valid = slv_req_i[1];
    assign slv_p_ready = slv_req_i[0];
    assign mst_p       = mst_rsp_i[PWidth+1:2];
    assign mst_p_valid = mst_rsp_i[1];
    assign mst_q_ready = mst_rsp_i[0];

    assign mst_req_o = {mst_q, mst_q_valid, mst_p_ready};
    assign slv_rsp_o = {slv_p, slv_p_valid, slv_q_ready};

    // The counter only falls while a request waits, so gating valid with credit keeps it stable.
    assign credit_ok   = (outstanding_q < OutWidth'(MaxOutstanding));
    assign mst_q_valid = req_head_valid & credit_ok;
    assign issue       = mst_q_valid & mst_q_ready;
    assign retire      = slv_p_valid & slv_p_ready;

    reqrsp_buffer_fifo #(
        .Width      (QWidth),
        .Depth      (ReqDepth),
        .UsageWidth (ReqUsageWidth)
    ) i_req_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_valid_i (slv_q_valid),
        .push_data_i  (slv_q),
        .push_ready_o (slv_q_ready),
        .pop_valid_o  (req_head_valid),
        .pop_data_o   (mst_q),
        .pop_ready_i  (mst_q_ready & credit_ok),
        .usage_o      (req_usage_o)
    );

    reqrsp_buffer_fifo #(
        .Width      (PWidth),
        .Depth      (RspDepth),
        .UsageWidth (RspUsageWidth)
    ) i_rsp_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_valid_i (mst_p_valid),
        .push_data_i  (mst_p),
        .push_ready_o (mst_p_ready),
        .pop_valid_o  (slv_p_valid),
        .pop_data_o   (slv_p),
        .pop_ready_i  (slv_p_ready),
        .usage_o      (rsp_usage_o)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue && !retire) begin
            outstanding_d = outstanding_q + OutWidth'(1);
        end else if (!issue && retire && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OutWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // A response with nothing in flight means the downstream slave broke the protocol.
    always_ff @(posedge clk_i) begin
        if (rst_ni && retire) begin
            assert (outstanding_q != '0);
        end
    end

    assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_reqrsp_buffer.sv
// Randomized bench for reqrsp_buffer: a buffered instance and a bypass instance, each compared
// every cycle against a queue-based model of the link (FIFO contents, credits, downstream slave).

module tb_reqrsp_buffer;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int UW   = 2;
    localparam int QW   = AW + 1 + DW + DW / 8 + UW;
    localparam int PW   = DW + 1 + UW;
    localparam int REQW = QW + 2;
    localparam int RSPW = PW + 2;
    localparam int RD[2]  = '{3, 0};
    localparam int PD[2]  = '{2, 0};
    localparam int MAX[2] = '{3, 2};
    localparam int NCYC    = 2400;
    localparam int RST_CYC = 1150;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [REQW-1:0] slv_req [2];
    logic [RSPW-1:0] slv_rsp [2];
    logic [REQW-1:0] mst_req [2];
    logic [RSPW-1:0] mst_rsp [2];
    logic [1:0]      ru0, pu0, ou0, ou1;
    logic            ru1, pu1;

    logic [QW-1:0] reqq    [2][$];
    logic [PW-1:0] rspq    [2][$];
    logic [QW-1:0] slvpend [2][$];
    int            outs    [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reqrsp_buffer #(
        .AddrWidth(AW), .DataWidth(DW), .UserWidth(UW),
        .ReqDepth(3), .RspDepth(2), .MaxOutstanding(3)
    ) u_buf (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(slv_req[0]), .slv_rsp_o(slv_rsp[0]),
        .mst_req_o(mst_req[0]), .mst_rsp_i(mst_rsp[0]),
        .req_usage_o(ru0), .rsp_usage_o(pu0), .outstanding_o(ou0)
    );

    reqrsp_buffer #(
        .AddrWidth(AW), .DataWidth(DW), .UserWidth(UW),
        .ReqDepth(0), .RspDepth(0), .MaxOutstanding(2)
    ) u_byp (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(slv_req[1]), .slv_rsp_o(slv_rsp[1]),
        .mst_req_o(mst_req[1]), .mst_rsp_i(mst_rsp[1]),
        .req_usage_o(ru1), .rsp_usage_o(pu1), .outstanding_o(ou1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model(input int k);
        reqq[k].delete();
        rspq[k].delete();
        slvpend[k].delete();
        outs[k] = 0;
    endtask

    task automatic step(input int k, input int cyc, input int pv, input int pr, input int qr, input int rv);
        logic [QW-1:0]   sq, e_mq;
        logic [PW-1:0]   mp, e_sp;
        logic            sqv, spr, mqr, mpv;
        logic            e_sqr, e_mqv, e_mpr, e_spv;
        logic            s_hs, m_hs, mp_hs, sp_hs;
        logic [REQW-1:0] mreq;
        logic [RSPW-1:0] srsp;
        int              ru, pu, ou, e_ru, e_pu;
        string           id;

        sq  = QW'({$urandom(), $urandom()});
        mp  = PW'($urandom());
        sqv = (int'($urandom_range(99)) < pv);
        spr = (int'($urandom_range(99)) < pr);
        mqr = (int'($urandom_range(99)) < qr);
        mpv = (slvpend[k].size() > 0) && (int'($urandom_range(99)) < rv);
        slv_req[k] = {sq, sqv, spr};
        mst_rsp[k] = {mp, mpv, mqr};
        #1;

        mreq = mst_req[k];
        srsp = slv_rsp[k];
        ru = (k == 0) ? int'(ru0) : int'(ru1);
        pu = (k == 0) ? int'(pu0) : int'(pu1);
        ou = (k == 0) ? int'(ou0) : int'(ou1);

        if (RD[k] > 0) begin
            e_sqr = (reqq[k].size() < RD[k]);
            e_mqv = (reqq[k].size() > 0) && (outs[k] < MAX[k]);
            e_mq  = (reqq[k].size() > 0) ? reqq[k][0] : '0;
            e_ru  = reqq[k].size();
        end else begin
            e_sqr = mqr && (outs[k] < MAX[k]);
            e_mqv = sqv && (outs[k] < MAX[k]);
            e_mq  = sq;
            e_ru  = 0;
        end
        if (PD[k] > 0) begin
            e_mpr = (rspq[k].size() < PD[k]);
            e_spv = (rspq[k].size() > 0);
            e_sp  = (rspq[k].size() > 0) ? rspq[k][0] : '0;
            e_pu  = rspq[k].size();
        end else begin
            e_mpr = spr;
            e_spv = mpv;
            e_sp  = mp;
            e_pu  = 0;
        end

        id = $sformatf("dut%0d cyc%0d", k, cyc);
        check({id, " slv_q_ready"}, 64'(srsp[0]), 64'(e_sqr));
        check({id, " mst_q_valid"}, 64'(mreq[1]), 64'(e_mqv));
        check({id, " mst_p_ready"}, 64'(mreq[0]), 64'(e_mpr));
        check({id, " slv_p_valid"}, 64'(srsp[1]), 64'(e_spv));
        check({id, " req_usage"}, 64'(ru), 64'(e_ru));
        check({id, " rsp_usage"}, 64'(pu), 64'(e_pu));
        check({id, " outstanding"}, 64'(ou), 64'(outs[k]));
        if (e_mqv) check({id, " mst_q"}, 64'(mreq[REQW-1:2]), 64'(e_mq));
        if (e_spv) check({id, " slv_p"}, 64'(srsp[RSPW-1:2]), 64'(e_sp));

        s_hs  = sqv && e_sqr;
        m_hs  = e_mqv && mqr;
        mp_hs = mpv && e_mpr;
        sp_hs = e_spv && spr;
        if (RD[k] > 0) begin
            if (m_hs) void'(reqq[k].pop_front());
            if (s_hs) reqq[k].push_back(sq);
        end
        if (mp_hs) void'(slvpend[k].pop_front());
        if (m_hs) slvpend[k].push_back(e_mq);
        if (PD[k] > 0) begin
            if (sp_hs) void'(rspq[k].pop_front());
            if (mp_hs) rspq[k].push_back(mp);
        end
        outs[k] = outs[k] + (m_hs ? 1 : 0) - (sp_hs ? 1 : 0);
    endtask

    initial begin
        int pv, pr, qr, rv;
        for (int k = 0; k < 2; k++) begin
            slv_req[k] = '0;
            mst_rsp[k] = '0;
            clear_model(k);
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc < 2 || cyc == RST_CYC) begin
                rst_n = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    slv_req[k] = '0;
                    mst_rsp[k] = '0;
                    clear_model(k);
                end
            end else begin
                rst_n = 1'b1;
                case ((cyc / 200) % 4)
                    0: begin pv = 90; pr = 90; qr = 90; rv = 90; end
                    1: begin pv = 80; pr = 90; qr = 0;  rv = 90; end
                    2: begin pv = 90; pr = 10; qr = 90; rv = 90; end
                    default: begin pv = 50; pr = 50; qr = 50; rv = 50; end
                endcase
                if (((cyc / 200) % 4) == 1 && (cyc % 200) > 150) qr = 60;
                for (int k = 0; k < 2; k++) begin
                    step(k, cyc, pv, pr, qr, rv);
                end
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reqrsp_buffer.md
# reqrsp_buffer

Parametrised, fully registered buffer for one `reqrsp` link, successor to the plain two-channel cut. Each channel has an independently sized FIFO (depth 0 = bypass), so a link can absorb downstream back-pressure rather than only break timing. An outstanding-transaction limiter caps requests in flight. Occupancy/credit status is exported for performance counters. The block sits between a `reqrsp` master (core, DMA, crossbar port) and a slave, on cluster-level paths where latency tolerance is needed.

## Interface
- `AddrWidth`, 0, request address width; must be >0.
- `DataWidth`, 0, data width; multiple of 8; strobe width is DataWidth/8.
- `UserWidth`, 0, user-signal width.
- `req_t`, logic, request struct (`q`, `q_valid`, `p_ready`).
- `rsp_t`, logic, response struct (`p`, `p_valid`, `q_ready`).
- `ReqDepth`, 2, request FIFO entries; 0 = combinational bypass.
- `RspDepth`, 2, response FIFO entries; 0 = combinational bypass.
- `MaxOutstanding`, 4, max requests issued on `mst` and not yet returned on `slv`; range 1..255.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  **synchronous, active-low** reset, sampled on `clk_i` rising edge.
- `slv_req_i`  in  req_t  request from the upstream master.
- `slv_rsp_o`  out  rsp_t  response to the upstream master.
- `mst_req_o`  out  req_t  request to the downstream slave.
- `mst_rsp_i`  in  rsp_t  response from the downstream slave.
- `req_usage_o`  out  $clog2(ReqDepth+1)  request FIFO fill level (0 when bypassed).
- `rsp_usage_o`  out  $clog2(RspDepth+1)  response FIFO fill level (0 when bypassed).
- `outstanding_o`  out  $clog2(MaxOutstanding+1)  current in-flight count.

## Operation
- Request path: push on `slv q_valid & q_ready`; `slv q_ready` = !req_full, from registered state only.
- Request pop: `mst q_valid` = !req_empty & (outstanding < MaxOutstanding); `mst q` = FIFO head.
- Response path: push on `mst p_valid & p_ready`; `mst p_ready` = !rsp_full.
- Response pop: `slv p_valid` = !rsp_empty; `slv p` = FIFO head.
- Outstanding counter:
  - +1 on `mst q` handshake.
  - −1 on `slv p` handshake.
  - Both in the same cycle: unchanged.
  - Never exceeds MaxOutstanding; never underflows. A `slv p` handshake at count 0 is an assertion error.
- Valid stability: once `mst q_valid` rises it holds until handshake. This is guaranteed because the counter can only decrease while a request waits.
- FIFO pointers are `$clog2(Depth)` wide and wrap modulo Depth. Full/empty is tracked by the usage counter, not pointer equality, so non-power-of-two depths are legal.
- Bypass: Depth 0 connects the channel combinationally. The outstanding limiter stays active in bypass mode.
- Payload passes unmodified; order is preserved per channel; no reordering, merging or dropping.

## Timing
- Reset (`rst_ni` low at a clock edge): FIFOs empty, pointers 0, counter 0.
- Outputs after reset: `slv q_ready`=1 (0 if ReqDepth=0 and `mst q_ready`=0), `slv p_valid`=0, `mst q_valid`=0, `mst p_ready`=1, all usage/outstanding outputs 0.
- Reset mid-operation discards all buffered beats and in-flight credits. No output glitches before the sampling edge.
- Latency per buffered channel: 1 cycle. A beat pushed at edge N is visible at the output after edge N, i.e. from cycle N+1.
- No combinational path from input to output on buffered channels: valid→valid and ready→ready are both cut.
- Throughput: Depth ≥ 2 sustains 1 beat/cycle. Depth 1 sustains 1 beat per 2 cycles, since ready comes from registered full.
- Full FIFO: ready=0 even when a pop occurs in the same cycle; ready returns the cycle after the pop.
- Empty FIFO: valid=0; a push does not appear in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: usage unchanged, both pointers advance.

## Test plan
- Single read, depths 2/2, Max 4:
  - Request at cycle 0 appears on `mst` at cycle 1.
  - Response returned at cycle 3 appears on `slv` at cycle 4.
  - `outstanding_o` goes 0→1 at cycle 2, then back to 0 at cycle 5.
- Streaming, ReqDepth 2, `mst q_ready`=1: 16 back-to-back requests emerge on 16 consecutive cycles, in order, data bit-exact.
- Back-pressure, ReqDepth 3, `mst q_ready`=0:
  - `slv q_ready` drops after 3 accepted beats; `req_usage_o`=3.
  - Releasing ready drains in order and `slv q_ready` returns one cycle after the first pop.
- Credit limit, Max 2, slave never responds:
  - Exactly 2 requests issued; `mst q_valid`=0 with the third held in the FIFO; `outstanding_o`=2.
  - One response delivered on `slv` re-enables issue on the next cycle.
- Bypass, ReqDepth=RspDepth=0: same-cycle pass-through on both channels; usage outputs stay 0; limiter still stops at Max.
- Reset with 2 requests buffered and 1 in flight: next cycle all usage/outstanding = 0, `mst q_valid`=0, and a fresh request completes normally.
